// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate generator: format-select codes,
// pipeline control states and the XLEN legality check.
package imm_gen_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_RSVD  = 3'b111;

    // Occupancy of the output register / skid buffer pair.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: instruction word and format
// select in, XLEN-wide immediate and reserved-select flag out.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm_ext,
    output logic            imm_err
);

    logic [31:0] raw;
    logic        sext;

    // Assemble the 32-bit immediate and note whether it widens signed.
    always_comb begin
        raw     = '0;
        sext    = 1'b0;
        imm_err = 1'b0;
        case (imm_src)
            IMM_I: begin
                raw  = {{20{instr[31]}}, instr[31:20]};
                sext = 1'b1;
            end
            IMM_S: begin
                raw  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                sext = 1'b1;
            end
            IMM_B: begin
                raw  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
                sext = 1'b1;
            end
            IMM_U: begin
                raw  = {instr[31:12], 12'b0};
                sext = 1'b1;
            end
            IMM_J: begin
                raw  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
                sext = 1'b1;
            end
            IMM_SHAMT: begin
                // RV64 shifts take a 6-bit amount, RV32 a 5-bit one.
                if (XLEN == 64) raw = {26'b0, instr[25:20]};
                else            raw = {27'b0, instr[24:20]};
            end
            IMM_ZIMM: begin
                raw = {27'b0, instr[19:15]};
            end
            default: begin
                imm_err = 1'b1;
            end
        endcase
    end

    // Widen to XLEN; a no-op for XLEN=32.
    always_comb begin
        if (sext) imm_ext = XLEN'($signed(raw));
        else      imm_ext = XLEN'(raw);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode in front of a registered
// valid/ready stage with a one-entry skid buffer. in_ready comes from
// registered state only, so out_ready never reaches it combinationally.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic            imm_err
);

    if (!xlen_legal(XLEN)) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    logic            dec_err;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .imm_ext (dec_imm),
        .imm_err (dec_err)
    );

    pipe_state_e     state_q, state_d;
    logic [XLEN-1:0] out_imm_q, skid_imm_q;
    logic            out_err_q, skid_err_q;

    logic accept, pop;
    logic load_out_in, load_out_skid, load_skid;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Next state; flush overrides any same-cycle accept or pop.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !pop)      state_d = ST_FULL;
                    else if (pop && !accept) state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs and data-register load enables.
    always_comb begin
        in_ready      = (state_q != ST_FULL);
        out_valid     = (state_q != ST_EMPTY);
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: load_out_in = accept;
                ST_ONE: begin
                    load_out_in = accept && pop;
                    load_skid   = accept && !pop;
                end
                ST_FULL:  load_out_skid = pop;
                default: ;
            endcase
        end
    end

    // Output and skid data registers; stale contents are harmless when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm_q  <= '0;
            out_err_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            if (load_out_in) begin
                out_imm_q <= dec_imm;
                out_err_q <= dec_err;
            end else if (load_out_skid) begin
                out_imm_q <= skid_imm_q;
                out_err_q <= skid_err_q;
            end
            if (load_skid) begin
                skid_imm_q <= dec_imm;
                skid_err_q <= dec_err;
            end
        end
    end

    assign imm_ext = out_imm_q;
    assign imm_err = out_err_q;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RISC-V datapath; next generation of the combinational I/S-only sign extender. Decodes all RV32I/RV64I immediate formats (I, S, B, U, J), shift amounts and CSR zimm from a 32-bit instruction word. Registered valid/ready stage with a one-entry skid buffer, so it can sit between fetch/decode and execute once the core is pipelined. Reports illegal format selects.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64. Sets imm_ext width and shamt width.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; drops all held entries
- in_valid  in  1  instr/imm_src valid
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- instr  in  32  instruction word
- imm_src  in  3  format select (see Operation)
- out_valid  out  1  imm_ext/imm_err valid
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- imm_ext  out  XLEN  extended immediate
- imm_err  out  1  imm_src was reserved (111) for this entry

## Operation
- imm_src encoding, with s = sign bit instr[31] replicated to XLEN:
  - 000 I: s, instr[31:20]
  - 001 S: s, instr[31:25], instr[11:7]
  - 010 B: s, instr[7], instr[30:25], instr[11:8], 0
  - 011 U: s above bit 31, instr[31:12], 12'b0 (XLEN=32: no sign bits)
  - 100 J: s, instr[19:12], instr[20], instr[30:21], 0
  - 101 SHAMT: zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64)
  - 110 ZIMM: zero-extended instr[19:15]
  - 111 reserved: imm_ext = 0, imm_err = 1
- imm_err = 0 for every other code.
- Control states, from out_valid and the skid-valid bit:
  - EMPTY: out_valid=0.
  - ONE: output register full, skid empty.
  - FULL: both full.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept and no pop -> FULL; new entry goes to skid.
  - ONE + pop and no accept -> EMPTY.
  - ONE + accept and pop -> ONE; output reloads from input.
  - FULL + pop -> ONE; output reloads from skid.
- in_ready = !skid_valid. It depends only on registered state, with no combinational path from out_ready.
- Entries leave in acceptance order.
- flush: next state EMPTY. Takes priority over a same-cycle accept, and the accepted entry is dropped. Data registers may keep stale values. in_ready is 1 in the cycle after flush.
- Decode happens before the register. Skid holds the already-decoded imm_ext and imm_err.

## Timing
- Reset (async assert, sync release inside the flop): out_valid=0, imm_ext=0, imm_err=0, skid empty, in_ready=1 while rst_n low and after.
- Latency: accept in cycle N gives out_valid in N+1 when state was EMPTY, or when state was ONE with a same-cycle pop.
- Throughput: 1 per cycle with out_ready held high.
- Under stall: at most 2 entries held. in_ready falls the cycle after the second accept and rises the cycle after the pop that empties the skid.
- imm_ext and imm_err stay stable while out_valid && !out_ready.
- Reset asserted mid-operation: all held entries are lost immediately and outputs go to reset values asynchronously.

## Structure
- Shared package imm_gen_pkg holds:
  - imm_src codes as named 3-bit constants (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM, IMM_RSVD).
  - The XLEN legality check.
- Sub-module imm_decode: purely combinational instr, imm_src -> imm_ext, imm_err, parametrised by XLEN. It is reusable by the single-cycle core.
- imm_gen_pipe contains the output register, skid register and control.

## Test plan
- Formats, XLEN=32, out_ready=1. Each result appears one cycle after accept:
  - I 0xFFF00093 -> 0xFFFFFFFF
  - S 0xFE20AE23 -> 0xFFFFFFFC
  - B 0xFE000CE3 -> 0xFFFFFFF8
  - U 0x123450B7 -> 0x12345000
  - J 0xFFDFF0EF -> 0xFFFFFFFC
- SHAMT 0x01F0D093 -> 0x0000001F; ZIMM 0x000FD073 -> 0x0000001F; imm_src=111 -> imm_ext=0, imm_err=1.
- Backpressure: out_ready=0, offer 3 back-to-back I entries (imm 1, 2, 3). Only 1 and 2 are accepted and in_ready drops. Raise out_ready: outputs 1, 2, then 3, with no loss or duplication.
- Flush in FULL together with in_valid: next cycle out_valid=0, in_ready=1, and the flushed and same-cycle entries never appear.
- Assert rst_n low for 1 cycle mid-stream while FULL: out_valid=0 and imm_ext=0 immediately, and the stream restarts cleanly.
- XLEN=64: I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF; U 0x800000B7 -> 0xFFFFFFFF80000000; SHAMT 0x03F0D093 -> 0x000000000000003F.
